// File: rtl/sigmoid_issue_ctrl.sv
// Issue/return controller sharing one 4-lane sigmoid pipe between two MAC requesters.
// Optional macro SIGMOID_CTRL_ERRDROP_EN: errored results are dropped instead of written back.
//
// state   | meaning
// S_IDLE  | no requests pending, all credits home
// S_RUN   | issuing and/or results outstanding
// S_DRAIN | flush requested: no grants, waiting for pipe and FIFO to empty
// S_DONE  | drain complete, flush_done pulses for this cycle
module sigmoid_issue_ctrl #(
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [1:0]     rq_valid,
  output logic [1:0]     rq_ready,
  input  logic [7:0]     rq_word_sel,
  input  logic [9:0]     rq_index,
  input  logic [255:0]   rq_data,
  output logic           sg_reg_wen,
  output logic [3:0]     sg_word_sel,
  output logic [4:0]     sg_index,
  output logic [127:0]   sg_data,
  input  logic           sg_reg_wen_o,
  input  logic [3:0]     sg_word_sel_o,
  input  logic [4:0]     sg_index_o,
  input  logic [127:0]   sg_result,
  input  logic [3:0]     sg_error,
  input  logic           sg_empty,
  output logic           wb_wen,
  input  logic           wb_ready,
  output logic [3:0]     wb_word_sel,
  output logic [4:0]     wb_index,
  output logic [127:0]   wb_data,
  input  logic           flush_req,
  output logic           flush_done,
  output logic [3:0]     err_status,
  input  logic           err_clr
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RES_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   credits;
  logic               rr_ptr;
  logic [1:0]         gnt;
  logic               gnt_any, gnt_sel, eligible;

  logic [3:0]         f_ws   [RES_DEPTH];
  logic [4:0]         f_idx  [RES_DEPTH];
  logic [127:0]       f_data [RES_DEPTH];
  logic [3:0]         f_err  [RES_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fill;
  logic               fifo_empty, fifo_full, push, pop, head_ok;

  // A rising flush_req blocks grants in the very cycle it is seen.
  assign eligible = (state != S_DRAIN) && !flush_req && (credits != '0);

  always_comb begin
    gnt = '0;
    if (eligible && !RST) begin
      if (rq_valid[rr_ptr])       gnt[rr_ptr]  = 1'b1;
      else if (rq_valid[~rr_ptr]) gnt[~rr_ptr] = 1'b1;
    end
  end

  assign rq_ready = gnt;
  assign gnt_any  = |gnt;
  assign gnt_sel  = gnt[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr      <= 1'b0;
      sg_reg_wen  <= 1'b0;
      sg_word_sel <= '0;
      sg_index    <= '0;
      sg_data     <= '0;
    end else begin
      sg_reg_wen <= gnt_any;
      if (gnt_any) begin
        rr_ptr      <= ~gnt_sel;
        sg_word_sel <= gnt_sel ? rq_word_sel[7:4]   : rq_word_sel[3:0];
        sg_index    <= gnt_sel ? rq_index[9:5]      : rq_index[4:0];
        sg_data     <= gnt_sel ? rq_data[255:128]   : rq_data[127:0];
      end
    end
  end

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FULL_CNT);
  assign push       = sg_reg_wen_o;

`ifdef SIGMOID_CTRL_ERRDROP_EN
  assign head_ok = (f_err[rd_ptr] == 4'b0000);
  assign pop     = !fifo_empty && (!head_ok || wb_ready);
`else
  assign head_ok = 1'b1;
  assign pop     = !fifo_empty && wb_ready;
`endif

  assign wb_wen      = !fifo_empty && head_ok;
  assign wb_word_sel = wb_wen ? f_ws[rd_ptr]   : '0;
  assign wb_index    = wb_wen ? f_idx[rd_ptr]  : '0;
  assign wb_data     = wb_wen ? f_data[rd_ptr] : '0;

  // Storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      f_ws[wr_ptr]   <= sg_word_sel_o;
      f_idx[wr_ptr]  <= sg_index_o;
      f_data[wr_ptr] <= sg_result;
      f_err[wr_ptr]  <= sg_error;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Saturate on return so orphan results after a reset cannot mint credits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credits <= FULL_CNT;
    end else begin
      case ({gnt_any, pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   if (credits != FULL_CNT) credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          err_status <= '0;
    else if (err_clr) err_status <= '0;
    else if (push)    err_status <= err_status | sg_error;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (flush_req)      state_nxt = S_DRAIN;
               else if (|rq_valid) state_nxt = S_RUN;
      S_RUN:   if (flush_req)      state_nxt = S_DRAIN;
               else if (credits == FULL_CNT && !(|rq_valid)) state_nxt = S_IDLE;
      S_DRAIN: if (credits == FULL_CNT && sg_empty && fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign flush_done = (state == S_DONE);

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full && !pop));

endmodule
